fine_dual_capture_encoder: RTL and testbench
============================================

Name: fine_dual_capture_encoder

Overview:
- Fine-time stage of the TDC; successor to the fixed-width start/stop capture columns.
- Samples a raw delay-chain tap vector into a metastability column, then latches separate Start and Stop columns under enable strobes.
- Bubble-corrects and thermometer-encodes both captured columns with a shared two-stage encoder; supports rising- or falling-edge hits.
- Delivers both fine codes on a valid/ready interface to the coarse/timestamp combiner.

Parameters:
- NUM_TAPS, 128: chain length; multiple of 4, range 16..512.
- CODE_W, $clog2(NUM_TAPS+1): fine code width.
- TOLERANCE, 4: tap index driven to the arbiter outputs; must be < NUM_TAPS.
- EDGE_MODE, 0: 0 counts ones (rising hit); 1 counts zeros (falling hit, taps inverted before filtering).

Ports:
- clk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iTaps  in  NUM_TAPS  raw carry-chain outputs; asynchronous to clk; tap 0 is the chain entry.
- iStartEnable  in  1  one-cycle strobe; capture the Start column.
- iStopEnable  in  1  one-cycle strobe; capture the Stop column.
- oArbStart  out  1  Start column bit [TOLERANCE].
- oArbStop  out  1  Stop column bit [TOLERANCE].
- oStartCode  out  CODE_W  encoded Start fine code.
- oStopCode  out  CODE_W  encoded Stop fine code.
- oStartSat  out  1  Start code is 0 or NUM_TAPS.
- oStopSat  out  1  Stop code is 0 or NUM_TAPS.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts the result.
- oMiss  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:
- Reset: all columns, codes, flags, oValid and oMiss are 0; FSM goes to IDLE. Reset is asynchronous, so it clears the block immediately, including mid-encode or mid-output; in-flight results are discarded.
- First column: registers iTaps on every edge, no enable.
- Start column: loads the first column on an edge where iStartEnable=1 and the state is IDLE.
- Stop column: loads the first column on an edge where iStopEnable=1 and the state is IDLE or ARMED.
- Column latency: iTaps to column = 2 edges.
- FSM states and transitions:
  - IDLE: on iStartEnable and iStopEnable together, capture both, go to ENC. On iStartEnable alone, go to ARMED.
  - ARMED: on iStopEnable, capture Stop, go to ENC.
  - ENC: fixed 4 cycles, then go to OUT.
  - OUT: hold; on oValid && iReady, go to IDLE.
- oValid rises exactly 4 edges after the Stop-capture edge.
- oValid and all code/flag outputs stay stable while iReady=0.
- oMiss pulses for 1 cycle in each of these cases:
  - iStartEnable in ARMED, ENC or OUT (ignored).
  - iStopEnable in IDLE without start, or in ENC or OUT (ignored).
- Encoder input: t = column XOR {NUM_TAPS{EDGE_MODE}}.
- Bubble filter: m[i] = majority(t[i-1], t[i], t[i+1]); boundary values t[-1]=1 and t[NUM_TAPS]=0.
- Code = popcount(m), range 0..NUM_TAPS. Two pipeline stages: stage 1 is the filter plus 4-bit partial sums; stage 2 is the adder tree.
- Shared encoder scheduling: the Start column enters first, the Stop column one cycle later.
- Sat flag: set when the code equals 0 or NUM_TAPS.
- Arbiter outputs: oArbStart and oArbStop are the raw column bits [TOLERANCE], not inverted or filtered, and update whenever their column loads.
- When Start and Stop capture on the same edge, the two codes are equal.

Test Plan (NUM_TAPS=16, TOLERANCE=4, EDGE_MODE=0 unless stated):
- Basic sequence:
  - Stimulus: iTaps=0x00FF, start strobe; then iTaps=0x0FFF, stop strobe; iReady=1.
  - Response: oValid 4 edges after the stop capture; oStartCode=8, oStopCode=12, both Sat=0; oArbStart=1, oArbStop=1.
- Bubble correction and saturation:
  - Stimulus: start taps=0x00F7, stop taps=0x0000.
  - Response: oStartCode=8; oStopCode=0 with oStopSat=1.
- Falling-edge mode and saturation (EDGE_MODE=1):
  - Stimulus: start taps=0xFF00, stop taps=0x0000.
  - Response: oStartCode=8; oStopCode=16 with oStopSat=1.
- Simultaneous strobes, backpressure and drop:
  - Stimulus: iStartEnable and iStopEnable in the same cycle with taps=0x003F; hold iReady=0 for 10 cycles; pulse iStartEnable during the hold.
  - Response: both codes = 6, held stable; oMiss pulses once; the transfer completes on iReady=1; the state returns to IDLE.
- Out-of-order strobes and reset:
  - Stimulus: iStopEnable in IDLE; then a start, then iRst asserted mid-ENC.
  - Response: oMiss pulses for the stray stop; outputs and columns go to 0 immediately on reset; no oValid appears; the next start/stop pair encodes normally.

Source files
------------

// File: rtl/fine_dual_capture_encoder.sv
// TDC fine-time stage: metastability column, Start/Stop capture columns and a
// shared two-stage bubble-correcting thermometer encoder behind a valid/ready port.
module fine_dual_capture_encoder #(
    parameter int NUM_TAPS  = 128,
    parameter int CODE_W    = $clog2(NUM_TAPS + 1),
    parameter int TOLERANCE = 4,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                iRst,
    input  logic [NUM_TAPS-1:0] iTaps,
    input  logic                iStartEnable,
    input  logic                iStopEnable,
    output logic                oArbStart,
    output logic                oArbStop,
    output logic [CODE_W-1:0]   oStartCode,
    output logic [CODE_W-1:0]   oStopCode,
    output logic                oStartSat,
    output logic                oStopSat,
    output logic                oValid,
    input  logic                iReady,
    output logic                oMiss
);

    localparam int GROUPS = NUM_TAPS / 4;

    typedef enum logic [1:0] {IDLE, ARMED, ENC, OUT} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              enc_cnt;
    logic [NUM_TAPS-1:0]     meta_col, start_col, stop_col;
    logic                    load_start, load_stop, miss_nxt;
    logic [NUM_TAPS-1:0]     enc_in;
    logic                    vld_p1, sel_p1, vld_p2, sel_p2;
    logic [3*GROUPS-1:0]     part_p1;
    logic [CODE_W-1:0]       code_p2;

    // Majority of each tap with its neighbours; below tap 0 reads as 1, above the top as 0.
    function automatic logic [NUM_TAPS-1:0] bubble_filter(input logic [NUM_TAPS-1:0] t);
        logic [NUM_TAPS+1:0] ext;
        logic [NUM_TAPS-1:0] m;
        ext = {1'b0, t, 1'b1};
        for (int i = 0; i < NUM_TAPS; i++) begin
            m[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return m;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] b);
        return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
    endfunction

    function automatic logic [CODE_W-1:0] sum_parts(input logic [3*GROUPS-1:0] p);
        logic [CODE_W-1:0] acc;
        acc = '0;
        for (int g = 0; g < GROUPS; g++) begin
            acc = acc + CODE_W'(p[3*g +: 3]);
        end
        return acc;
    endfunction

    function automatic logic is_sat(input logic [CODE_W-1:0] code);
        return (code == '0) || (code == CODE_W'(NUM_TAPS));
    endfunction

    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        load_stop  = 1'b0;
        miss_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (iStartEnable) begin
                    load_start = 1'b1;
                    if (iStopEnable) begin
                        load_stop = 1'b1;
                        state_nxt = ENC;
                    end else begin
                        state_nxt = ARMED;
                    end
                end else if (iStopEnable) begin
                    // A lone Stop still refreshes its column but no measurement starts.
                    load_stop = 1'b1;
                    miss_nxt  = 1'b1;
                end
            end
            ARMED: begin
                miss_nxt = iStartEnable;
                if (iStopEnable) begin
                    load_stop = 1'b1;
                    state_nxt = ENC;
                end
            end
            ENC: begin
                miss_nxt = iStartEnable | iStopEnable;
                if (enc_cnt == 2'd3) state_nxt = OUT;
            end
            OUT: begin
                miss_nxt = iStartEnable | iStopEnable;
                if (iReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state      <= IDLE;
            enc_cnt    <= '0;
            meta_col   <= '0;
            start_col  <= '0;
            stop_col   <= '0;
            oMiss      <= 1'b0;
            vld_p1     <= 1'b0;
            sel_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            sel_p2     <= 1'b0;
            oStartCode <= '0;
            oStopCode  <= '0;
            oStartSat  <= 1'b0;
            oStopSat   <= 1'b0;
        end else begin
            state    <= state_nxt;
            enc_cnt  <= (state == ENC) ? enc_cnt + 2'd1 : 2'd0;
            meta_col <= iTaps;
            oMiss    <= miss_nxt;
            if (load_start) start_col <= meta_col;
            if (load_stop)  stop_col  <= meta_col;
            // Start goes through the encoder on the first ENC cycle, Stop on the second.
            vld_p1 <= (state == ENC) && (enc_cnt < 2'd2);
            sel_p1 <= enc_cnt[0];
            vld_p2 <= vld_p1;
            sel_p2 <= sel_p1;
            if (vld_p2 && !sel_p2) begin
                oStartCode <= code_p2;
                oStartSat  <= is_sat(code_p2);
            end
            if (vld_p2 && sel_p2) begin
                oStopCode <= code_p2;
                oStopSat  <= is_sat(code_p2);
            end
        end
    end

    assign enc_in = enc_cnt[0] ? stop_col : start_col;

    // Stage 1: edge polarity, bubble filter, 4-tap partial sums
    always_ff @(posedge clk) begin
        logic [NUM_TAPS-1:0] m;
        m = bubble_filter(enc_in ^ {NUM_TAPS{EDGE_MODE}});
        for (int g = 0; g < GROUPS; g++) begin
            part_p1[3*g +: 3] <= popcount4(m[4*g +: 4]);
        end
    end

    // Stage 2: adder tree over the partial sums
    always_ff @(posedge clk) begin
        code_p2 <= sum_parts(part_p1);
    end

    assign oValid    = (state == OUT);
    assign oArbStart = start_col[TOLERANCE];
    assign oArbStop  = stop_col[TOLERANCE];

endmodule

// File: tb/tb_fine_dual_capture_encoder.sv
// Bench for fine_dual_capture_encoder: a rising-edge and a falling-edge instance
// share stimulus and are compared against a tap-level reference model.
module tb_fine_dual_capture_encoder;

    logic        clk = 1'b0;
    logic        iRst = 1'b1;
    logic [15:0] iTaps = '0;
    logic        iStartEnable = 1'b0;
    logic        iStopEnable = 1'b0;
    logic        iReady = 1'b0;

    logic        arb_start [2];
    logic        arb_stop  [2];
    logic [4:0]  start_code [2];
    logic [4:0]  stop_code  [2];
    logic        start_sat [2];
    logic        stop_sat  [2];
    logic        valid     [2];
    logic        miss      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fine_dual_capture_encoder #(
            .NUM_TAPS(16), .TOLERANCE(4), .EDGE_MODE(g == 1)
        ) dut (
            .clk(clk), .iRst(iRst), .iTaps(iTaps),
            .iStartEnable(iStartEnable), .iStopEnable(iStopEnable),
            .oArbStart(arb_start[g]), .oArbStop(arb_stop[g]),
            .oStartCode(start_code[g]), .oStopCode(stop_code[g]),
            .oStartSat(start_sat[g]), .oStopSat(stop_sat[g]),
            .oValid(valid[g]), .iReady(iReady), .oMiss(miss[g])
        );
    end

    // Reference: count taps whose 3-tap majority (edges padded 1 below, 0 above) is 1.
    function automatic logic [4:0] ref_code(input logic [15:0] col, input int mode);
        int t[18];
        int n;
        n = 0;
        t[0] = 1;
        t[17] = 0;
        for (int i = 0; i < 16; i++) t[i+1] = (col[i] ? 1 : 0) ^ mode;
        for (int i = 0; i < 16; i++) if (t[i] + t[i+1] + t[i+2] >= 2) n++;
        return 5'(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit same,
                         output int lat);
        iTaps = a;
        step();
        iStartEnable = 1'b1;
        iStopEnable = same;
        step();
        iStartEnable = 1'b0;
        iStopEnable = 1'b0;
        if (!same) begin
            iTaps = b;
            step();
            iStopEnable = 1'b1;
            step();
            iStopEnable = 1'b0;
        end
        lat = 0;
        while (valid[0] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        step();
        step();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({start_code[m], stop_code[m], start_sat[m], stop_sat[m], valid[m], miss[m],
                 arb_start[m], arb_stop[m]} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got %h %h %b%b%b%b%b%b want all zero", m,
                         start_code[m], stop_code[m], start_sat[m], stop_sat[m], valid[m],
                         miss[m], arb_start[m], arb_stop[m]);
            end
        end
        iRst = 1'b0;
        step();
        checks++;
        if (valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid got %b want 0", valid[0]);
        end
    endtask

    // Directed vectors: basic sequence, bubble correction, saturation in both edge modes.
    task automatic test_vectors();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [4:0]  es, ep;
        int lat;
        va[0] = 16'h00FF; vb[0] = 16'h0FFF;
        va[1] = 16'h00F7; vb[1] = 16'h0000;
        va[2] = 16'hFF00; vb[2] = 16'h0000;
        iReady = 1'b1;
        for (int v = 0; v < 3; v++) begin
            issue(va[v], vb[v], 1'b0, lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL vec%0d_latency got %0d want 4", v, lat);
            end
            for (int m = 0; m < 2; m++) begin
                es = ref_code(va[v], m);
                ep = ref_code(vb[v], m);
                checks++;
                if (valid[m] !== 1'b1 || start_code[m] !== es || stop_code[m] !== ep) begin
                    errors++;
                    $display("FAIL vec%0d_codes[%0d] got v=%b %0d/%0d want v=1 %0d/%0d", v, m,
                             valid[m], start_code[m], stop_code[m], es, ep);
                end
                checks++;
                if (start_sat[m] !== (es == 0 || es == 16) || stop_sat[m] !== (ep == 0 || ep == 16)) begin
                    errors++;
                    $display("FAIL vec%0d_sat[%0d] got %b%b for codes %0d/%0d", v, m,
                             start_sat[m], stop_sat[m], es, ep);
                end
                checks++;
                if (arb_start[m] !== va[v][4] || arb_stop[m] !== vb[v][4]) begin
                    errors++;
                    $display("FAIL vec%0d_arb[%0d] got %b%b want %b%b", v, m,
                             arb_start[m], arb_stop[m], va[v][4], vb[v][4]);
                end
            end
            step();
            checks++;
            if (valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_handshake valid got %b want 0", v, valid[0]);
            end
        end
        iReady = 1'b0;
    endtask

    task automatic test_back_to_back_hold();
        logic [4:0] e [2];
        int lat, misses, waited;
        iReady = 1'b0;
        issue(16'h003F, 16'h0000, 1'b1, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL same_edge_latency got %0d want 4", lat);
        end
        for (int m = 0; m < 2; m++) e[m] = ref_code(16'h003F, m);
        misses = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) iStartEnable = 1'b1;
            step();
            iStartEnable = 1'b0;
            if (miss[0] === 1'b1) misses++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (valid[m] !== 1'b1 || start_code[m] !== e[m] || stop_code[m] !== e[m]) begin
                    errors++;
                    $display("FAIL hold%0d[%0d] got v=%b %0d/%0d want v=1 %0d/%0d", k, m,
                             valid[m], start_code[m], stop_code[m], e[m], e[m]);
                end
            end
        end
        checks++;
        if (misses != 1) begin
            errors++;
            $display("FAIL hold_miss_pulses got %0d want 1", misses);
        end
        iReady = 1'b1;
        step();
        iReady = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release valid got %b want 0", valid[0]);
        end
        // Back in IDLE: a fresh Start is accepted without a miss.
        iTaps = 16'h0001;
        step();
        iStartEnable = 1'b1;
        step();
        iStartEnable = 1'b0;
        checks++;
        if (miss[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_miss got %b want 0", miss[0]);
        end
        iTaps = 16'h0003;
        step();
        iStopEnable = 1'b1;
        step();
        iStopEnable = 1'b0;
        waited = 0;
        while (valid[0] !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (waited != 4) begin
            errors++;
            $display("FAIL idle_start_latency got %0d want 4", waited);
        end
        iReady = 1'b1;
        step();
        iReady = 1'b0;
    endtask

    task automatic test_stray_stop_and_reset();
        logic [15:0] stray;
        int lat, seen;
        stray = 16'h1234;
        iTaps = stray;
        step();
        iStopEnable = 1'b1;
        step();
        iStopEnable = 1'b0;
        checks++;
        if (miss[0] !== 1'b1 || miss[1] !== 1'b1 || arb_stop[0] !== stray[4]) begin
            errors++;
            $display("FAIL stray_stop got miss=%b%b arb=%b want miss=11 arb=%b",
                     miss[0], miss[1], arb_stop[0], stray[4]);
        end
        step();
        checks++;
        if (miss[0] !== 1'b0 || valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL stray_stop_after got miss=%b valid=%b want 0 0", miss[0], valid[0]);
        end
        iTaps = 16'h00FF;
        step();
        iStartEnable = 1'b1;
        step();
        iStartEnable = 1'b0;
        iTaps = 16'h0FFF;
        step();
        iStopEnable = 1'b1;
        step();
        iStopEnable = 1'b0;
        step();
        step();
        #2 iRst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({start_code[m], stop_code[m], start_sat[m], stop_sat[m], valid[m], miss[m],
                 arb_start[m], arb_stop[m]} !== 16'h0) begin
                errors++;
                $display("FAIL mid_enc_reset[%0d] got %h %h %b%b%b%b%b%b want all zero", m,
                         start_code[m], stop_code[m], start_sat[m], stop_sat[m], valid[m],
                         miss[m], arb_start[m], arb_stop[m]);
            end
        end
        step();
        step();
        iRst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (valid[0] === 1'b1 || valid[1] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_discard valid cycles got %0d want 0", seen);
        end
        iReady = 1'b1;
        issue(16'h07FF, 16'h7FFF, 1'b0, lat);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (lat != 4 || start_code[m] !== ref_code(16'h07FF, m) ||
                stop_code[m] !== ref_code(16'h7FFF, m)) begin
                errors++;
                $display("FAIL post_reset[%0d] got lat=%0d %0d/%0d want lat=4 %0d/%0d", m, lat,
                         start_code[m], stop_code[m], ref_code(16'h07FF, m), ref_code(16'h7FFF, m));
            end
        end
        step();
        iReady = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [4:0]  es, ep;
        bit same;
        int lat, hold;
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 3 == 0) a = 16'hFFFF >> $urandom_range(0, 16);
            same = ($urandom_range(0, 3) == 0);
            if (same) b = a;
            iReady = 1'b0;
            issue(a, b, same, lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL rand%0d_latency got %0d want 4", n, lat);
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) step();
            for (int m = 0; m < 2; m++) begin
                es = ref_code(a, m);
                ep = ref_code(b, m);
                checks++;
                if (valid[m] !== 1'b1 || start_code[m] !== es || stop_code[m] !== ep ||
                    start_sat[m] !== (es == 0 || es == 16) || stop_sat[m] !== (ep == 0 || ep == 16) ||
                    arb_start[m] !== a[4] || arb_stop[m] !== b[4]) begin
                    errors++;
                    $display("FAIL rand%0d[%0d] taps %h/%h got v=%b %0d/%0d sat=%b%b arb=%b%b want %0d/%0d",
                             n, m, a, b, valid[m], start_code[m], stop_code[m], start_sat[m],
                             stop_sat[m], arb_start[m], arb_stop[m], es, ep);
                end
            end
            iReady = 1'b1;
            step();
            iReady = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back_hold();
        test_stray_stop_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
